// File: rtl/frame_rd_scheduler.sv
// Frame-buffer read scheduler: one read command per active line at base + n*stride,
// with a bounded number of commands in flight, double buffering and overrun counting.
module frame_rd_scheduler #(
  parameter int AXI_AWIDTH      = 32,
  parameter int LINES_W         = 12,
  parameter int BYTES_W         = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [AXI_AWIDTH-1:0] cfg_base0,
  input  logic [AXI_AWIDTH-1:0] cfg_base1,
  input  logic [AXI_AWIDTH-1:0] cfg_stride,
  input  logic [BYTES_W-1:0]    cfg_line_bytes,
  input  logic [LINES_W-1:0]    cfg_num_lines,
  input  logic                  cfg_dbuf,
  output logic                  m_cmd_tvalid,
  input  logic                  m_cmd_tready,
  output logic [AXI_AWIDTH-1:0] m_cmd_addr,
  output logic [BYTES_W-1:0]    m_cmd_bytes,
  input  logic                  s_status_tvalid,
  output logic                  s_status_tready,
  input  logic [1:0]            s_status_resp,
  output logic                  busy,
  output logic                  buf_sel,
  output logic                  frame_done,
  output logic                  err,
  input  logic                  err_clr,
  output logic [15:0]           overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [3:0]         MAX_OUT  = 4'(MAX_OUTSTANDING);
  localparam logic [LINES_W-1:0] LINE_ONE = LINES_W'(1);

  state_e                  state_q, state_d;
  logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
  logic [AXI_AWIDTH-1:0]   stride_q, stride_d;
  logic [BYTES_W-1:0]      bytes_q, bytes_d;
  logic [LINES_W-1:0]      lineIdx_q, lineIdx_d;
  logic [LINES_W-1:0]      numLines_q, numLines_d;
  logic                    dbuf_q, dbuf_d;
  logic                    bufSel_q, bufSel_d;
  logic                    frameDone_q, frameDone_d;
  logic                    err_q, err_d;
  logic [15:0]             overrun_q, overrun_d;
  logic [3:0]              outstanding_q, outstanding_d;
  logic                    statusReady_q;

  logic cmdHs;
  logic stsHs;

  // Valid depends only on registered state, so it cannot drop before the handshake.
  assign m_cmd_tvalid = (state_q == ISSUE) && (outstanding_q < MAX_OUT);
  assign cmdHs        = m_cmd_tvalid && m_cmd_tready;
  assign stsHs        = s_status_tvalid && statusReady_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    bytes_d       = bytes_q;
    lineIdx_d     = lineIdx_q;
    numLines_d    = numLines_q;
    dbuf_d        = dbuf_q;
    bufSel_d      = bufSel_q;
    frameDone_d   = 1'b0;
    err_d         = err_q;
    overrun_d     = overrun_q;
    outstanding_d = outstanding_q;

    // A status with nothing outstanding is a stray and is simply dropped.
    if (cmdHs && !stsHs) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!cmdHs && stsHs && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end

    if (stsHs && (s_status_resp != 2'b00)) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    if (frame_start && (state_q != IDLE) && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (frame_start && enable) begin
          addr_d     = bufSel_q ? cfg_base1 : cfg_base0;
          stride_d   = cfg_stride;
          bytes_d    = cfg_line_bytes;
          numLines_d = cfg_num_lines;
          dbuf_d     = cfg_dbuf;
          lineIdx_d  = '0;
          state_d    = (cfg_num_lines == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (cmdHs) begin
          addr_d    = addr_q + stride_q;
          lineIdx_d = lineIdx_q + LINE_ONE;
          if (lineIdx_q == (numLines_q - LINE_ONE)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outstanding_d == 4'd0) begin
          state_d     = IDLE;
          frameDone_d = 1'b1;
          if (dbuf_q) begin
            bufSel_d = ~bufSel_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      bytes_q       <= '0;
      lineIdx_q     <= '0;
      numLines_q    <= '0;
      dbuf_q        <= 1'b0;
      bufSel_q      <= 1'b0;
      frameDone_q   <= 1'b0;
      err_q         <= 1'b0;
      overrun_q     <= '0;
      outstanding_q <= '0;
      statusReady_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      bytes_q       <= bytes_d;
      lineIdx_q     <= lineIdx_d;
      numLines_q    <= numLines_d;
      dbuf_q        <= dbuf_d;
      bufSel_q      <= bufSel_d;
      frameDone_q   <= frameDone_d;
      err_q         <= err_d;
      overrun_q     <= overrun_d;
      outstanding_q <= outstanding_d;
      statusReady_q <= 1'b1;
    end
  end

  assign m_cmd_addr      = addr_q;
  assign m_cmd_bytes     = bytes_q;
  assign s_status_tready = statusReady_q;
  assign busy            = (state_q != IDLE);
  assign buf_sel         = bufSel_q;
  assign frame_done      = frameDone_q;
  assign err             = err_q;
  assign overrun_cnt     = overrun_q;

endmodule

// File: doc/frame_rd_scheduler.md
# frame_rd_scheduler

Sequences frame-buffer reads for the video output path. On each frame-start pulse it issues one read command per active line to the AXI read master, at `base + n*stride`. It limits the number of commands outstanding and waits for every line's completion status. It supports double buffering, and reports completion, errors and overruns to the register block.

## Interface
Parameters:
- `AXI_AWIDTH`, 32, address width.
- `LINES_W`, 12, width of the line count/index.
- `BYTES_W`, 16, width of the per-line byte count.
- `MAX_OUTSTANDING`, 2, maximum number of commands issued but not yet completed (1..15).

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allows a new frame to start; sampled only in IDLE.
- `frame_start`  in  1  one-cycle pulse from video timing (vsync-derived).
- `cfg_base0` / `cfg_base1`  in  AXI_AWIDTH  frame-buffer base addresses for buffers 0 and 1.
- `cfg_stride`  in  AXI_AWIDTH  byte distance between line start addresses.
- `cfg_line_bytes`  in  BYTES_W  bytes read per line.
- `cfg_num_lines`  in  LINES_W  lines per frame.
- `cfg_dbuf`  in  1  1 = alternate buffers frame to frame.
- `m_cmd_tvalid` out / `m_cmd_tready` in  1  command handshake toward the read master.
- `m_cmd_addr`  out  AXI_AWIDTH  line start address.
- `m_cmd_bytes`  out  BYTES_W  line byte count.
- `s_status_tvalid` in / `s_status_tready` out  1  per-command completion from the read master.
- `s_status_resp`  in  2  AXI response of the completed command (0 = OKAY).
- `busy`  out  1  high when not in IDLE.
- `buf_sel`  out  1  buffer used by the current or next frame.
- `frame_done`  out  1  one-cycle pulse when a frame is complete.
- `err`  out  1  sticky error flag.
- `err_clr`  in  1  clears `err`.
- `overrun_cnt`  out  16  count of ignored `frame_start` pulses, saturating.

## Operation
- States:
  - IDLE: waits for a frame to start.
  - ISSUE: issues line commands.
  - DRAIN: waits for outstanding completions.
- IDLE -> ISSUE on `frame_start && enable`. In that cycle:
  - latch all `cfg_*` inputs; they are ignored for the rest of the frame;
  - base = `buf_sel ? cfg_base1 : cfg_base0`; `m_cmd_addr` <= base;
  - `line_idx` <= 0; `m_cmd_bytes` <= `cfg_line_bytes`.
- `cfg_num_lines == 0`: go straight from IDLE to DRAIN; no command is issued.
- `m_cmd_tvalid` = (state == ISSUE) && (`outstanding` < `MAX_OUTSTANDING`).
  - Once asserted it stays high until the handshake, because `outstanding` can only fall in ISSUE.
  - `m_cmd_addr` and `m_cmd_bytes` stay stable while valid is high.
- On each command handshake:
  - `m_cmd_addr` += latched stride, modulo 2^AXI_AWIDTH (wrap, no flag);
  - `line_idx` += 1;
  - if `line_idx` was `num_lines-1`, go ISSUE -> DRAIN.
- `outstanding` counter:
  - +1 on a command handshake, -1 on a status handshake;
  - both in the same cycle: no change;
  - a status while `outstanding == 0` (stray, e.g. after reset) is accepted and discarded; no underflow.
- `s_status_tready` is held at 1 in every state after reset.
- DRAIN -> IDLE when `outstanding == 0`, including the cycle in which the last status is accepted. On that transition:
  - pulse `frame_done`;
  - if `cfg_dbuf` was latched as 1, toggle `buf_sel`.
- `err`:
  - set by any accepted status with `s_status_resp != 0`;
  - cleared by `err_clr`;
  - set and clear in the same cycle: set wins.
  - The frame always continues to completion after an error.
- `frame_start` while not in IDLE: `overrun_cnt` += 1, saturating at 0xFFFF; the pulse is otherwise ignored.
- `frame_start` in IDLE with `enable == 0`: ignored, not counted.
- Dropping `enable` mid-frame has no effect until the frame completes.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0; `s_status_tready` = 0 during reset and 1 from the first clock edge after release.
- Reset mid-frame aborts immediately. No command is reissued; completions still in flight are absorbed as stray statuses.
- `frame_start` sampled at edge T:
  - `m_cmd_tvalid` is high in cycle T+1 with `m_cmd_addr` = base;
  - `busy` is high from T+1.
- With `m_cmd_tready` held at 1 and `outstanding` below the limit, one command is issued per cycle.
- `frame_done` asserts the cycle after the last status handshake, or the cycle after DRAIN is entered when `num_lines == 0`. `busy` is low in that same cycle.
- A `frame_start` in the `frame_done` cycle is accepted, because the state is already IDLE.

## Test plan
- Base0 = 0x1000_0000, stride 0x800, bytes 1440, 4 lines; tready and status returned immediately. Expect commands at 0x1000_0000 / 0800 / 1000 / 1800, each with bytes 1440; one `frame_done`; `buf_sel` stays 0 with `cfg_dbuf` = 0.
- `MAX_OUTSTANDING` = 2, status withheld. Expect exactly 2 commands then `m_cmd_tvalid` low. Return one status: the 3rd command is issued the following cycle.
- `cfg_dbuf` = 1, base1 = 0x2000_0000, three frames. Expect first addresses 0x1000_0000, 0x2000_0000, 0x1000_0000; `buf_sel` toggles after each `frame_done`.
- Status `resp` = 2 on line 1 of 3. Expect `err` = 1, all 3 lines still issued, `frame_done` asserted. `err_clr` coincident with a new error leaves `err` = 1.
- `frame_start` pulsed 3 times mid-frame. Expect `overrun_cnt` = 3 and no frame restart. With `num_lines` = 0: `frame_done` at T+2 and no command.
- Base 0xFFFF_F800, stride 0x800, 2 lines. Expect addresses 0xFFFF_F800 then 0x0000_0000. Assert `rst_n` low mid-frame: all outputs 0, then 1 stray status is accepted with no underflow.
